// File: rtl/uart_rx_ctrl.sv
// Receive-side byte buffer: gates/filters receiver bytes into a show-ahead FIFO with valid/ready output,
// one-edge push/pop latency, full FIFO drops the byte and sets sticky overrun; idle timer flags end of message.
module uart_rx_ctrl #(
    parameter int DEPTH     = 16,
    parameter int IDLE_CLKS = 52080,
    parameter bit DROP_ERR  = 1'b1
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       rx_en,
    input  logic                       flush,
    input  logic                       clr_status,
    input  logic [7:0]                 rx_data,
    input  logic                       rx_done,
    input  logic                       rx_error,
    input  logic                       rx_busy,
    output logic [7:0]                 out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     fill_level,
    output logic                       overrun,
    output logic [7:0]                 err_count,
    output logic                       idle_timeout
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {DISARMED, ARMED} idle_state_e;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          overrun_q, overrun_d;
    logic [7:0]    err_q, err_d;
    idle_state_e   state_q, state_d;
    logic [23:0]   timer_q, timer_d;
    logic          idle_q, idle_d;

    logic rx_evt, err_evt, push_req, full, pop, push_ok, ovr_evt;

    always_comb begin
        rx_evt   = rx_done & rx_en;
        err_evt  = rx_evt & rx_error;
        push_req = rx_evt & ~(rx_error & DROP_ERR);
        full     = (cnt_q == CW'(DEPTH));
        out_valid = (cnt_q != '0);
        pop      = out_valid & out_ready;
        // A same-cycle pop frees the slot, so a full FIFO can still accept.
        push_ok  = push_req & (~full | pop);
        ovr_evt  = push_req & full & ~pop & ~flush;
        out_data = out_valid ? mem_q[rd_q] : 8'h00;
    end

    always_comb begin
        rd_d  = rd_q;
        wr_d  = wr_q;
        cnt_d = cnt_q;
        if (flush) begin
            rd_d  = '0;
            wr_d  = '0;
            cnt_d = '0;
        end else begin
            if (push_ok) wr_d = wr_q + AW'(1);
            if (pop)     rd_d = rd_q + AW'(1);
            cnt_d = cnt_q + CW'(push_ok) - CW'(pop);
        end
    end

    // Set events take priority over a same-cycle clear.
    always_comb begin
        overrun_d = overrun_q;
        err_d     = err_q;
        if (clr_status) begin
            overrun_d = 1'b0;
            err_d     = 8'h00;
        end
        if (ovr_evt) overrun_d = 1'b1;
        if (err_evt) err_d = clr_status ? 8'h01 : ((err_q == 8'hFF) ? err_q : err_q + 8'h01);
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        idle_d  = 1'b0;
        if (!rx_en) begin
            state_d = DISARMED;
            timer_d = '0;
        end else if (rx_done) begin
            state_d = ARMED;
            timer_d = '0;
        end else if (state_q == ARMED) begin
            if (rx_busy) begin
                timer_d = '0;
            end else if (timer_q == 24'(IDLE_CLKS - 1)) begin
                idle_d  = 1'b1;
                state_d = DISARMED;
            end else begin
                timer_d = timer_q + 24'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_q      <= '0;
            wr_q      <= '0;
            cnt_q     <= '0;
            overrun_q <= 1'b0;
            err_q     <= 8'h00;
            state_q   <= DISARMED;
            timer_q   <= '0;
            idle_q    <= 1'b0;
        end else begin
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            cnt_q     <= cnt_d;
            overrun_q <= overrun_d;
            err_q     <= err_d;
            state_q   <= state_d;
            timer_q   <= timer_d;
            idle_q    <= idle_d;
        end
    end

    // Storage needs no reset: out_data is masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push_ok && !flush) mem_q[wr_q] <= rx_data;
    end

    assign fill_level   = cnt_q;
    assign overrun      = overrun_q;
    assign err_count    = err_q;
    assign idle_timeout = idle_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl (DEPTH=16, IDLE_CLKS=20, DROP_ERR=1).
module tb_uart_rx_ctrl;

    logic       clk = 1'b0;
    logic       reset_n, rx_en, flush, clr_status, rx_done, rx_error, rx_busy, out_ready;
    logic [7:0] rx_data;
    logic [7:0] out_data;
    logic       out_valid, overrun, idle_timeout;
    logic [4:0] fill_level;
    logic [7:0] err_count;

    int n_vec = 0;
    int n_err = 0;

    uart_rx_ctrl #(.DEPTH(16), .IDLE_CLKS(20), .DROP_ERR(1'b1)) dut (
        .clk(clk), .reset_n(reset_n), .rx_en(rx_en), .flush(flush),
        .clr_status(clr_status), .rx_data(rx_data), .rx_done(rx_done),
        .rx_error(rx_error), .rx_busy(rx_busy), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .fill_level(fill_level),
        .overrun(overrun), .err_count(err_count), .idle_timeout(idle_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d, input logic e);
        rx_data  = d;
        rx_error = e;
        rx_done  = 1'b1;
        tick();
        rx_done  = 1'b0;
        rx_error = 1'b0;
    endtask

    // k counts edges after the call; rx_busy is high for edges busy_from..busy_to-1.
    task automatic watch_idle(input int ncyc, input int busy_from, input int busy_to,
                              output int pulses, output int at);
        pulses = 0;
        at     = -1;
        for (int k = 1; k <= ncyc; k++) begin
            rx_busy = (k >= busy_from) && (k < busy_to);
            tick();
            if (idle_timeout) begin
                pulses++;
                at = k;
            end
        end
        rx_busy = 1'b0;
    endtask

    logic [7:0] exp_q[$];
    int p1, a1, p2, a2;

    initial begin
        reset_n = 1'b0; rx_en = 1'b1; flush = 1'b0; clr_status = 1'b0;
        rx_done = 1'b0; rx_error = 1'b0; rx_busy = 1'b0; out_ready = 1'b0;
        rx_data = 8'h00;
        #12;
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_fill", fill_level, 0);
        chk("rst_ovr", overrun, 0);
        chk("rst_err", err_count, 0);
        chk("rst_idle", idle_timeout, 0);
        @(negedge clk) reset_n = 1'b1;
        tick();

        // In-order delivery through show-ahead head
        push(8'h55, 0); push(8'hA3, 0); push(8'h0F, 0);
        chk("fill3", fill_level, 3);
        chk("head55", out_data, 8'h55);
        out_ready = 1'b1;
        chk("pop55", out_data, 8'h55); tick();
        chk("popA3", out_data, 8'hA3); tick();
        chk("pop0F", out_data, 8'h0F); tick();
        chk("empty", out_valid, 0);
        out_ready = 1'b0;

        // Full FIFO: overflow drop, then push with simultaneous pop
        for (int i = 0; i < 16; i++) push(8'(8'h10 + i), 0);
        chk("full16", fill_level, 16);
        push(8'h99, 0);
        chk("ovr_set", overrun, 1);
        chk("ovr_fill", fill_level, 16);
        chk("ovr_head", out_data, 8'h10);
        out_ready = 1'b1;
        push(8'hAB, 0);
        out_ready = 1'b0;
        chk("pp_fill", fill_level, 16);
        chk("pp_head", out_data, 8'h11);
        exp_q.delete();
        for (int i = 1; i < 16; i++) exp_q.push_back(8'(8'h10 + i));
        exp_q.push_back(8'hAB);
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("drain%0d", i), out_data, exp_q[i]);
            tick();
        end
        out_ready = 1'b0;
        chk("drain_empty", out_valid, 0);
        clr_status = 1'b1; tick(); clr_status = 1'b0;
        chk("ovr_clr", overrun, 0);

        // Framing errors: dropped, counted, saturating
        push(8'h7E, 1);
        chk("err_fill", fill_level, 0);
        chk("err_cnt1", err_count, 1);
        for (int i = 0; i < 299; i++) push(8'h7E, 1);
        chk("err_sat", err_count, 255);
        chk("err_nostore", out_valid, 0);
        clr_status = 1'b1; tick(); clr_status = 1'b0;
        chk("err_clr", err_count, 0);
        clr_status = 1'b1; push(8'h7E, 1); clr_status = 1'b0;
        chk("err_clr_vs_set", err_count, 1);

        // Idle timeout
        rx_en = 1'b0; tick(); rx_en = 1'b1;
        push(8'h01, 0);
        watch_idle(25, 0, 0, p1, a1);
        chk("idle_once", p1, 1);
        chk("idle_at20", a1, 20);
        push(8'h02, 0);
        watch_idle(9, 0, 0, p1, a1);
        push(8'h03, 0);
        watch_idle(25, 0, 0, p2, a2);
        chk("rearm_none_early", p1, 0);
        chk("rearm_once", p2, 1);
        chk("rearm_at20", a2, 20);
        push(8'h04, 0);
        watch_idle(45, 15, 20, p1, a1);
        chk("busy_once", p1, 1);
        chk("busy_at39", a1, 39);

        // Flush
        flush = 1'b1; tick(); flush = 1'b0;
        chk("flush_clear", fill_level, 0);
        for (int i = 0; i < 5; i++) push(8'(8'h30 + i), 0);
        chk("fill5", fill_level, 5);
        flush = 1'b1; push(8'h88, 0); flush = 1'b0;
        chk("flush_fill", fill_level, 0);
        chk("flush_valid", out_valid, 0);
        chk("flush_ovr", overrun, 0);

        // rx_en low ignores strobes
        rx_en = 1'b0;
        push(8'h42, 0);
        push(8'h43, 1);
        chk("dis_fill", fill_level, 0);
        chk("dis_err", err_count, 1);
        watch_idle(25, 0, 0, p1, a1);
        chk("dis_noidle", p1, 0);
        rx_en = 1'b1;

        // Asynchronous reset mid-stream
        for (int i = 0; i < 17; i++) push(8'(8'h60 + i), 0);
        out_ready = 1'b1;
        for (int i = 0; i < 9; i++) tick();
        out_ready = 1'b0;
        chk("pre_fill7", fill_level, 7);
        chk("pre_ovr", overrun, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_data", out_data, 0);
        chk("arst_fill", fill_level, 0);
        chk("arst_ovr", overrun, 0);
        chk("arst_err", err_count, 0);
        chk("arst_idle", idle_timeout, 0);
        tick();
        @(negedge clk) reset_n = 1'b1;
        tick();
        chk("post_fill", fill_level, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Receive-side controller between the UART receiver core and the downstream byte consumer. It gates incoming frames with an enable, filters framing-errored bytes, and buffers accepted bytes in a DEPTH-entry FIFO with a valid/ready output. It also tracks overrun and frame-error status, and raises an end-of-message pulse when the line has been idle for a programmed time after the last byte.

## Interface
- DEPTH, 16: FIFO entries; power of two, 2..256.
- IDLE_CLKS, 52080: idle clocks after the last byte before idle_timeout fires (10 bit times at 50 MHz / 9600); range 1..2^24-1.
- DROP_ERR, 1: 1 = discard bytes received with rx_error=1; 0 = store them.
- clk  in  1  system clock, all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- rx_en  in  1  1 = accept bytes from the receiver core.
- flush  in  1  one-cycle pulse: empty the FIFO.
- clr_status  in  1  one-cycle pulse: clear overrun and err_count.
- rx_data  in  8  byte from receiver core; valid while rx_done=1.
- rx_done  in  1  one-cycle byte-complete strobe from receiver core.
- rx_error  in  1  stop-bit error qualifier; sampled with rx_done.
- rx_busy  in  1  receiver core is mid-frame.
- out_data  out  8  FIFO head byte (show-ahead).
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts out_data when out_valid=1.
- fill_level  out  $clog2(DEPTH)+1  number of stored bytes.
- overrun  out  1  sticky: a byte was lost to a full FIFO.
- err_count  out  8  frame-error count, saturating at 255.
- idle_timeout  out  1  one-cycle end-of-message pulse.

## Operation
- Push request: rx_done=1 and rx_en=1, and not (rx_error=1 and DROP_ERR=1).
- Pop: out_valid=1 and out_ready=1.
- Push accepted when fill_level<DEPTH, or when a pop occurs in the same cycle. If both occur while full, fill_level stays DEPTH and the order is preserved.
- Push rejected because the FIFO is full: byte dropped, overrun set to 1.
- Errored frame: rx_done=1, rx_en=1, rx_error=1 increments err_count, saturating at 255. This applies regardless of DROP_ERR.
- With rx_en=0, rx_done is ignored entirely: no push, no err_count change, no overrun.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. fill_level = pushes minus pops.
- flush: read pointer, write pointer, and fill_level go to 0; out_valid=0 next cycle. Flush overrides a same-cycle push or pop; that byte is lost and overrun is not set.
- clr_status with a same-cycle set event: the event wins. overrun ends at 1, or err_count ends at 1.
- Idle timer FSM, states DISARMED and ARMED:
  - DISARMED -> ARMED on an accepted or dropped byte (rx_done=1, rx_en=1); timer cleared to 0.
  - In ARMED: rx_busy=1 holds the timer at 0; otherwise the timer increments each cycle.
  - In ARMED, when the timer reaches IDLE_CLKS-1 and rx_busy=0: idle_timeout=1 for one cycle, go to DISARMED.
  - A new rx_done while ARMED re-clears the timer.
  - rx_en=0 forces DISARMED and clears the timer.
- The 24-bit timer never wraps; it stops on firing.

## Timing
- Reset (reset_n=0, asynchronous): FIFO empty, out_valid=0, out_data=0, fill_level=0, overrun=0, err_count=0, idle_timeout=0, timer FSM DISARMED.
- Reset mid-operation discards the FIFO contents and all status immediately.
- Push latency: rx_done at edge N; out_valid=1 and out_data valid after edge N (visible in cycle N+1); fill_level updates at the same edge.
- out_data is combinational from the head entry and is stable while out_valid=1 and no pop occurs.
- Pop at edge N: the next entry or out_valid=0 is visible after edge N.
- Simultaneous push and pop on an empty FIFO: the pop is not possible (out_valid=0); only the push takes effect.
- idle_timeout rises exactly IDLE_CLKS cycles after the edge that sampled the last rx_done, provided rx_busy stays 0 throughout.
- Status outputs (overrun, err_count) update one edge after the causing strobe.

## Test plan
- Reset, then push 0x55, 0xA3, 0x0F with out_ready=0 -> fill_level=3, out_data=0x55. Raise out_ready -> 0x55, 0xA3, 0x0F delivered in order, then out_valid=0.
- Fill DEPTH=16 bytes, push 0x99 with out_ready=0 -> 0x99 dropped, overrun=1, fill_level=16. Push with a same-cycle pop when full -> fill_level stays 16 and the byte appears last.
- DROP_ERR=1, rx_done with rx_error=1, data 0x7E -> not stored, err_count=1. Repeat 300 times -> err_count=255. clr_status -> 0.
- IDLE_CLKS=20, one byte then line idle -> idle_timeout pulses exactly once, 20 cycles after rx_done. A second byte at cycle 10 -> the pulse moves to 20 cycles after that byte. rx_busy=1 at cycle 15 -> the timer holds at 0.
- flush with fill_level=5 and a same-cycle push -> fill_level=0, out_valid=0, overrun unchanged. rx_en=0 plus rx_done -> no push, no timeout.
- Assert reset_n=0 mid-stream with fill_level=7 and overrun=1 -> all outputs return to reset values asynchronously.
